// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole lamp scheduler.
//   An LFSR picks which hole lights up, each mole stays lit for a programmable
//   number of cycles, and player hits are judged as hit_ok / hit_wrong / miss.
//   Each judgement is a registered one-cycle pulse.
//
// Optional feature (macro MOLE_NO_REPEAT_EN): two consecutive moles never use
//   the same hole. The first mole after IDLE is exempt. Requires NUM_MOLES >= 2.
//
// Ports:
//   clock      system clock
//   reset_n    asynchronous active-low reset
//   game       1 = running, 0 = return to IDLE, clear lamps/pulses, reseed
//   seed       LFSR seed, loaded while idle (0 is replaced by 1)
//   speed      mole on-time in cycles, sampled at mole start (0 acts as 1)
//   hit        one-cycle button pulses, bit i = hole i
//   mole       one-hot lit hole, 0 when none is lit
//   mole_idx   index of the current or most recent mole
//   hit_ok     pulse: lit hole was hit
//   hit_wrong  pulse: another hole was hit while a mole was lit
//   miss       pulse: mole timed out without being hit
//   busy       scheduler is not idle
module mole_scheduler #(
  parameter int unsigned           NUM_MOLES  = 3,
  parameter int unsigned           LFSR_W     = 8,
  parameter logic [LFSR_W-1:0]     LFSR_TAPS  = 8'hB8,
  parameter int unsigned           SPEED_W    = 28,
  parameter int unsigned           GAP_CYCLES = 2,
  localparam int unsigned          IDX_W      = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 game,
  input  logic [LFSR_W-1:0]    seed,
  input  logic [SPEED_W-1:0]   speed,
  input  logic [NUM_MOLES-1:0] hit,
  output logic [NUM_MOLES-1:0] mole,
  output logic [IDX_W-1:0]     mole_idx,
  output logic                 hit_ok,
  output logic                 hit_wrong,
  output logic                 miss,
  output logic                 busy
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [SPEED_W-1:0]     show_q, show_d;
  logic [NUM_MOLES-1:0]   mole_q, mole_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   ok_q, ok_d;
  logic                   wrong_q, wrong_d;
  logic                   miss_q, miss_d;
  logic                   busy_q, busy_d;
`ifdef MOLE_NO_REPEAT_EN
  logic                   first_q, first_d;
`endif

  logic [LFSR_W-1:0]      lfsr_step;
  logic [LFSR_W-1:0]      seed_val;
  logic [IDX_W-1:0]       cand;
  logic                   cand_ok;
  logic [SPEED_W-1:0]     speed_m1;

  // Datapath helpers: next LFSR value, sanitised seed/speed, candidate hole
  always_comb begin
    lfsr_step = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    seed_val  = (seed == '0) ? LFSR_W'(1) : seed;
    speed_m1  = (speed == '0) ? '0 : speed - SPEED_W'(1);
    cand      = lfsr_q[IDX_W-1:0];
`ifdef MOLE_NO_REPEAT_EN
    cand_ok   = (32'(cand) < NUM_MOLES) && (first_q || (cand != idx_q));
`else
    cand_ok   = (32'(cand) < NUM_MOLES);
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    gap_d   = gap_q;
    show_d  = show_q;
    mole_d  = mole_q;
    idx_d   = idx_q;
    ok_d    = 1'b0;
    wrong_d = 1'b0;
    miss_d  = 1'b0;
`ifdef MOLE_NO_REPEAT_EN
    first_d = first_q;
`endif

    case (state_q)
      IDLE: begin
        lfsr_d = seed_val;
`ifdef MOLE_NO_REPEAT_EN
        first_d = 1'b1;
`endif
        if (game) begin
          state_d = GAP;
          gap_d   = GAP_INIT;
        end
      end

      GAP: begin
        lfsr_d = lfsr_step;
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (cand_ok) begin
          // Rejected candidates simply wait for the next LFSR step
          state_d = SHOW;
          idx_d   = cand;
          mole_d  = NUM_MOLES'(1) << cand;
          show_d  = speed_m1;
`ifdef MOLE_NO_REPEAT_EN
          first_d = 1'b0;
`endif
        end
      end

      SHOW: begin
        lfsr_d = lfsr_step;
        // Correct hole wins over both a wrong bit and a simultaneous timeout
        if ((hit & mole_q) != '0) begin
          ok_d    = 1'b1;
          state_d = GAP;
          mole_d  = '0;
          gap_d   = GAP_INIT;
        end else if (hit != '0) begin
          wrong_d = 1'b1;
        end else if (show_q == '0) begin
          miss_d  = 1'b1;
          state_d = GAP;
          mole_d  = '0;
          gap_d   = GAP_INIT;
        end else begin
          show_d = show_q - SPEED_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        mole_d  = '0;
      end
    endcase

    // Stopping the game overrides every other decision
    if (!game) begin
      state_d = IDLE;
      lfsr_d  = seed_val;
      mole_d  = '0;
      ok_d    = 1'b0;
      wrong_d = 1'b0;
      miss_d  = 1'b0;
`ifdef MOLE_NO_REPEAT_EN
      first_d = 1'b1;
`endif
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_W'(1);
      gap_q   <= '0;
      show_q  <= '0;
      mole_q  <= '0;
      idx_q   <= '0;
      ok_q    <= 1'b0;
      wrong_q <= 1'b0;
      miss_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MOLE_NO_REPEAT_EN
      first_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      gap_q   <= gap_d;
      show_q  <= show_d;
      mole_q  <= mole_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      wrong_q <= wrong_d;
      miss_q  <= miss_d;
      busy_q  <= busy_d;
`ifdef MOLE_NO_REPEAT_EN
      first_q <= first_d;
`endif
    end
  end

  assign mole      = mole_q;
  assign mole_idx  = idx_q;
  assign hit_ok    = ok_q;
  assign hit_wrong = wrong_q;
  assign miss      = miss_q;
  assign busy      = busy_q;

endmodule
